// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours
// (decode/control reuse the opcode constants).
package fetch_pkg;

    // Canonical RISC-V NOP: addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;

endpackage

// File: rtl/fetch_unit_redirect_counter.sv
// redirect_counter: free-running count of accepted redirects, wraps at 2^W.
// Built only when FETCH_REDIRECT_CNT_EN is defined; in the default build the
// module does not exist at all so no stray counter logic is elaborated.
`ifdef FETCH_REDIRECT_CNT_EN
module redirect_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count every edge on which a redirect is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc)
            count <= count + W'(1);
    end

endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Owns the fetch PC, keeps one request outstanding on
// the imem req/gnt/rvalid port, loads the IF/ID register, honours load-use
// stalls and flushes on taken jumps/branches.
// Optional feature macro: FETCH_REDIRECT_CNT_EN (redirect_cnt counter).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            stall,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    output logic [6:0]      op,
    output logic            func,
    output logic            cancel,
    output logic [31:0]     redirect_cnt
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_inc, tgt;
    logic            drop_q, drop_d;
    // Pending buffer; its contents are meaningful exactly while in HOLD
    logic [31:0]     pend_instr_q;
    logic [XLEN-1:0] pend_pc_q;
    logic            pend_cap;
    logic            if_ld;
    logic [31:0]     if_instr_d;
    logic [XLEN-1:0] if_pc_d;
    logic            if_valid_d;
    logic [1:0]      cancel_q;

    // Redirect targets are word aligned; the mask reads every bit on purpose
    assign tgt    = jmp_target & {{(XLEN-2){1'b1}}, 2'b00};
    assign pc_inc = pc_q + XLEN'(4);

    // No request while reset is held even though the state is already REQ
    assign imem_req  = (state_q == REQ) && rst_n;
    assign imem_addr = pc_q;
    assign op        = instr[6:0];
    assign func      = instr[30];
    assign cancel    = (cancel_q != 2'd0);

    // Next-state, fetch PC, drop flag and IF/ID load decisions
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        pend_cap   = 1'b0;
        if_ld      = 1'b0;
        if_instr_d = NOP;
        if_pc_d    = pc_out;
        if_valid_d = 1'b0;
        if (jmp_en) begin
            // Redirect wins over stall and rvalid: flush IF/ID, drop pending
            pc_d  = tgt;
            if_ld = 1'b1;
            case (state_q)
                REQ: begin
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = REQ;
            endcase
        end else begin
            // Unstalled IF/ID takes a bubble unless something is delivered
            if_ld = !stall;
            case (state_q)
                REQ: begin
                    if (imem_gnt)
                        state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else if (!stall) begin
                            if_instr_d = imem_rdata;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                            pc_d       = pc_inc;
                            state_d    = REQ;
                        end else begin
                            pend_cap = 1'b1;
                            pc_d     = pc_inc;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_instr_d = pend_instr_q;
                        if_pc_d    = pend_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // FSM state, fetch PC and stale-response flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Pending buffer captures a response that arrived during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_instr_q <= 32'd0;
            pend_pc_q    <= '0;
        end else if (pend_cap) begin
            pend_instr_q <= imem_rdata;
            pend_pc_q    <= pc_q;
        end
    end

    // IF/ID register; holds whenever if_ld is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= NOP;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else if (if_ld) begin
            instr       <= if_instr_d;
            pc_out      <= if_pc_d;
            instr_valid <= if_valid_d;
        end
    end

    // Flush window: two cycles starting with the redirect edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cancel_q <= 2'd0;
        else if (jmp_en)
            cancel_q <= 2'd2;
        else if (cancel_q != 2'd0)
            cancel_q <= cancel_q - 2'd1;
    end

`ifdef FETCH_REDIRECT_CNT_EN
    redirect_counter #(.W(32)) u_redirect_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (jmp_en),
        .count (redirect_cnt)
    );
`else
    assign redirect_cnt = 32'd0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RISC-V pipeline, sitting directly upstream of the decode/control unit. It owns the program counter and issues one outstanding request at a time on a request/grant/response instruction-memory port. It delivers the fetched instruction, its opcode and funct bit into the IF/ID register, and drives the `cancel` flush used by control after a taken jump or branch. It also honours load-use stalls from the hazard logic.

## Interface
Parameters:
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  XLEN  request address; registered, equal to fetch PC.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction.
- `jmp_en`  in  1  taken jump/branch redirect from EX.
- `jmp_target`  in  XLEN  redirect address.
- `stall`  in  1  hold the IF/ID register (load-use).
- `instr`  out  32  IF/ID instruction.
- `pc_out`  out  XLEN  PC of `instr`.
- `instr_valid`  out  1  `instr` is real, not a bubble.
- `op`  out  7  `instr[6:0]`, combinational from `instr`.
- `func`  out  1  `instr[30]`, combinational from `instr`.
- `cancel`  out  1  flush to control.
- `redirect_cnt`  out  32  count of accepted redirects (see Configuration).

## Operation
- FSM states: REQ, WAIT, HOLD. Fetch PC register `pc_q`. One-entry pending buffer. `drop` flag.
- REQ: `imem_req`=1. `imem_gnt` -> WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`:
  - `drop`=1: discard the data, clear `drop`, go to REQ.
  - Otherwise, `stall`=0: load the IF/ID register with `instr_valid`=1 and `pc_out`=`pc_q`; set `pc_q`+=4; go to REQ.
  - Otherwise, `stall`=1: capture into pending; set `pc_q`+=4; go to HOLD.
- HOLD: no request. When `stall` falls, pending moves to IF/ID -> REQ.
- IF/ID update rule:
  - `stall`=1: `instr`, `pc_out` and `instr_valid` hold.
  - `stall`=0 with no instruction delivered: load NOP 32'h0000_0013 with `instr_valid`=0.
- Redirect (`jmp_en`=1), highest priority over `stall` and `rvalid`:
  - `pc_q`<=`jmp_target`.
  - IF/ID <= NOP with `instr_valid`=0.
  - Pending buffer invalidated.
- Redirect actions per state:
  - REQ without grant: stay in REQ with the new address.
  - REQ with `imem_gnt`, or WAIT without `rvalid`: set `drop`, go to WAIT.
  - WAIT with `rvalid` same cycle: data discarded, go to REQ.
  - HOLD: go to REQ.
- `cancel`: 2-bit down-counter, loaded with 2 on `jmp_en`. `cancel` = counter != 0. A new `jmp_en` reloads it to 2.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of `jmp_target` are forced to 0.

## Timing
- Reset values:
  - `pc_q`=`RESET_PC`, state REQ, `imem_req`=0 while `rst_n`=0.
  - `instr`=NOP, `instr_valid`=0, `pc_out`=0.
  - `cancel`=0, `drop`=0, `redirect_cnt`=0.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- Zero-wait memory (grant in the REQ cycle, `rvalid` in the next cycle): an instruction reaches IF/ID every 2 cycles. Latency from request issue to valid `instr` is 2 edges.
- After `jmp_en` at edge N:
  - `cancel`=1 for cycles N..N+1.
  - First request to the target is issued in cycle N unless `drop` is set; then it is issued after the stale response returns.
- Reset mid-transaction: all state clears. Any later stale `imem_rvalid` arriving in REQ is ignored.
- `op` and `func` follow `instr` with no extra latency.

## Configuration
- `FETCH_REDIRECT_CNT_EN` defined: 32-bit counter increments on every edge with `jmp_en`=1, wrapping at 2^32, and drives `redirect_cnt`.
- Not defined: `redirect_cnt` tied to 0 and no counter flops are built.

## Structure
- Package `fetch_pkg`:
  - NOP constant 32'h0000_0013.
  - FSM state enum {REQ, WAIT, HOLD}.
  - Opcode constants (OP_R 7'b0110011, OP_I, OP_JAL, OP_JALR, OP_BR, OP_LW, OP_SW) shared with control.
- Sub-module: `redirect_counter`, instantiated only under `FETCH_REDIRECT_CNT_EN`.

## Test plan
- Reset then free-running zero-wait memory returning `addr` as data:
  - `imem_addr` sequence 0, 4, 8.
  - `instr_valid` pulses every 2 cycles, with `pc_out` matching `instr`.
- `jmp_en` with `jmp_target`=32'h100 while in WAIT, then `rvalid` next cycle:
  - Stale data discarded.
  - Next `imem_addr`=32'h100.
  - `cancel` high exactly 2 cycles.
  - IF/ID shows NOP with `instr_valid`=0.
- `stall`=1 for 3 cycles while a response arrives:
  - `instr` holds.
  - Pending instruction appears in the cycle after `stall` falls; none lost, none duplicated.
- `jmp_en` and `stall` together in HOLD: pending discarded, fetch restarts at the target, `instr_valid`=0.
- Redirect to 32'hFFFF_FFFC: next fetch address is 0 (wrap).
- With `FETCH_REDIRECT_CNT_EN`, 5 redirects -> `redirect_cnt`=5. Without it, `redirect_cnt` stays 0.
